pipe_stage_ctrl: RTL and testbench



---
 rtl/mips_pkg.sv | 17 +
 rtl/pipe_reg.sv | 26 ++
 rtl/pipe_stage_ctrl.sv | 130 +++++++++++++
 tb/tb_pipe_stage_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants for the MIPS front-end pipeline
package mips_pkg;

    // Decoded control bundle: {RegWrite, MemtoReg, MemWrite, ALUControl[2:0], ALUSrc, RegDst}
    localparam int CTRL_W        = 8;
    localparam int CTRL_REGWRITE = 7;
    localparam int CTRL_MEMTOREG = 6;
    localparam int CTRL_MEMWRITE = 5;
    localparam int CTRL_ALU_HI   = 4;
    localparam int CTRL_ALU_LO   = 2;
    localparam int CTRL_ALUSRC   = 1;
    localparam int CTRL_REGDST   = 0;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

endpackage

// File: rtl/pipe_reg.sv
// rtl/pipe_reg.sv - generic pipeline register with enable and synchronous clear
module pipe_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;

    // Reset and clear both produce an all-zero bubble; otherwise load when enabled
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            q_q <= '0;
        end else if (en) begin
            q_q <= d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/pipe_stage_ctrl.sv
// rtl/pipe_stage_ctrl.sv - PC, IF/ID and ID/EX registers with stall/flush counters and watchdog
module pipe_stage_ctrl
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEF,
    parameter int          CTRL_W      = mips_pkg::CTRL_W,
    parameter int          STALL_LIMIT = 64,
    parameter int          CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              StallF,
    input  logic              StallD,
    input  logic              FlushE,
    input  logic              PCSrcD,
    input  logic [31:0]       PCNextF,
    input  logic [31:0]       InstrF,
    input  logic [31:0]       PCPlus4F,
    input  logic [CTRL_W-1:0] CtrlD,
    input  logic [31:0]       RD1D,
    input  logic [31:0]       RD2D,
    input  logic [31:0]       SignImmD,
    input  logic [4:0]        rsD_in,
    input  logic [4:0]        rtD_in,
    input  logic [4:0]        rdD_in,
    output logic [31:0]       PCF,
    output logic [31:0]       InstrD,
    output logic [31:0]       PCPlus4D,
    output logic              validD,
    output logic [CTRL_W-1:0] CtrlE,
    output logic [31:0]       RD1E,
    output logic [31:0]       RD2E,
    output logic [31:0]       SignImmE,
    output logic [4:0]        rsE,
    output logic [4:0]        rtE,
    output logic [4:0]        rdE,
    output logic              validE,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic              stall_timeout
);

    localparam int RUN_W  = $clog2(STALL_LIMIT + 1);
    localparam int IFID_W = 1 + 32 + 32;
    localparam int IDEX_W = 1 + CTRL_W + 32 * 3 + 5 * 3;

    logic [31:0]      pc_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;
    logic [RUN_W-1:0] run_q, run_d;
    logic             timeout_q, timeout_d;

    logic [IFID_W-1:0] ifid_d, ifid_q;
    logic [IDEX_W-1:0] idex_d, idex_q;

    // Fetch PC: freezes while fetch is stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else if (!StallF) begin
            pc_q <= PCNextF;
        end
    end

    // IF/ID: a stall in D takes priority over the branch-taken flush
    assign ifid_d = {1'b1, InstrF, PCPlus4F};

    pipe_reg #(.W(IFID_W)) u_ifid (
        .clk   (clk),
        .reset (reset),
        .en    (~StallD),
        .clr   (PCSrcD & ~StallD),
        .d     (ifid_d),
        .q     (ifid_q)
    );

    assign validD   = ifid_q[64];
    assign InstrD   = ifid_q[63:32];
    assign PCPlus4D = ifid_q[31:0];

    // ID/EX: never held, FlushE inserts a bubble; validity follows the D stage
    assign idex_d = {validD, CtrlD, RD1D, RD2D, SignImmD, rsD_in, rtD_in, rdD_in};

    pipe_reg #(.W(IDEX_W)) u_idex (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .clr   (FlushE),
        .d     (idex_d),
        .q     (idex_q)
    );

    assign {validE, CtrlE, RD1E, RD2E, SignImmE, rsE, rtE, rdE} = idex_q;

    // Watchdog run length: consecutive fetch stalls, saturating at the limit
    always_comb begin
        run_d = run_q;
        if (!StallF) begin
            run_d = '0;
        end else if (run_q != RUN_W'(STALL_LIMIT)) begin
            run_d = run_q + 1'b1;
        end
        timeout_d = timeout_q | (run_d == RUN_W'(STALL_LIMIT));
    end

    // Saturating performance counters and sticky watchdog flag
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            run_q       <= '0;
            timeout_q   <= 1'b0;
        end else begin
            if (StallF && stall_cnt_q != '1) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if ((FlushE || PCSrcD) && flush_cnt_q != '1) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
            run_q     <= run_d;
            timeout_q <= timeout_d;
        end
    end

    assign PCF           = pc_q;
    assign stall_cnt     = stall_cnt_q;
    assign flush_cnt     = flush_cnt_q;
    assign stall_timeout = timeout_q;

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// tb/tb_pipe_stage_ctrl.sv - scoreboard bench for pipe_stage_ctrl
module tb_pipe_stage_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_0400;
    localparam int CW    = 8;
    localparam int LIMIT = 64;
    localparam int CNTW  = 8;

    logic clk = 1'b0;
    logic reset, StallF, StallD, FlushE, PCSrcD;
    logic [31:0] PCNextF, InstrF, PCPlus4F, RD1D, RD2D, SignImmD;
    logic [CW-1:0] CtrlD;
    logic [4:0] rsD_in, rtD_in, rdD_in;
    logic [31:0] PCF, InstrD, PCPlus4D, RD1E, RD2E, SignImmE;
    logic validD, validE, stall_timeout;
    logic [CW-1:0] CtrlE;
    logic [4:0] rsE, rtE, rdE;
    logic [CNTW-1:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    pipe_stage_ctrl #(
        .RESET_PC    (RST_PC),
        .CTRL_W      (CW),
        .STALL_LIMIT (LIMIT),
        .CNT_W       (CNTW)
    ) dut (
        .clk (clk), .reset (reset),
        .StallF (StallF), .StallD (StallD), .FlushE (FlushE), .PCSrcD (PCSrcD),
        .PCNextF (PCNextF), .InstrF (InstrF), .PCPlus4F (PCPlus4F),
        .CtrlD (CtrlD), .RD1D (RD1D), .RD2D (RD2D), .SignImmD (SignImmD),
        .rsD_in (rsD_in), .rtD_in (rtD_in), .rdD_in (rdD_in),
        .PCF (PCF), .InstrD (InstrD), .PCPlus4D (PCPlus4D), .validD (validD),
        .CtrlE (CtrlE), .RD1E (RD1E), .RD2E (RD2E), .SignImmE (SignImmE),
        .rsE (rsE), .rtE (rtE), .rdE (rdE), .validE (validE),
        .stall_cnt (stall_cnt), .flush_cnt (flush_cnt), .stall_timeout (stall_timeout)
    );

    typedef struct {
        logic [31:0]     pc, instrd, pcp4d, rd1e, rd2e, imme;
        logic            vd, ve, to;
        logic [CW-1:0]   ctrle;
        logic [4:0]      rse, rte, rde;
        logic [CNTW-1:0] sc, fc;
    } exp_t;

    exp_t m;
    exp_t sb[$];
    int   run_m;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m = '{pc: RST_PC, instrd: 0, pcp4d: 0, rd1e: 0, rd2e: 0, imme: 0,
              vd: 0, ve: 0, to: 0, ctrle: 0, rse: 0, rte: 0, rde: 0, sc: 0, fc: 0};
        run_m = 0;
    endtask

    // Drive one cycle, predict the registered result, check it after the edge
    task automatic step(input logic rst, input logic sf, input logic sd, input logic fe,
                        input logic ps, input logic [31:0] pcn, input logic [31:0] ins);
        exp_t n;
        exp_t got;
        reset    = rst;  StallF = sf; StallD = sd; FlushE = fe; PCSrcD = ps;
        PCNextF  = pcn;  InstrF = ins;
        PCPlus4F = $urandom; CtrlD = CW'($urandom);
        RD1D = $urandom; RD2D = $urandom; SignImmD = $urandom;
        rsD_in = 5'($urandom); rtD_in = 5'($urandom); rdD_in = 5'($urandom);

        if (rst) begin
            model_reset();
        end else begin
            n = m;
            if (!sf) n.pc = pcn;
            if (!sd) begin
                if (ps) begin n.instrd = 0; n.pcp4d = 0; n.vd = 0; end
                else begin n.instrd = ins; n.pcp4d = PCPlus4F; n.vd = 1; end
            end
            if (fe) begin
                n.ctrle = 0; n.rd1e = 0; n.rd2e = 0; n.imme = 0;
                n.rse = 0; n.rte = 0; n.rde = 0; n.ve = 0;
            end else begin
                n.ctrle = CtrlD; n.rd1e = RD1D; n.rd2e = RD2D; n.imme = SignImmD;
                n.rse = rsD_in; n.rte = rtD_in; n.rde = rdD_in; n.ve = m.vd;
            end
            if (sf && m.sc != {CNTW{1'b1}}) n.sc = m.sc + 1'b1;
            if ((fe || ps) && m.fc != {CNTW{1'b1}}) n.fc = m.fc + 1'b1;
            run_m = sf ? ((run_m < LIMIT) ? run_m + 1 : LIMIT) : 0;
            if (run_m == LIMIT) n.to = 1'b1;
            m = n;
        end
        sb.push_back(m);

        @(posedge clk);
        @(negedge clk);
        got = sb.pop_front();
        chk("PCF",       PCF,                  got.pc);
        chk("InstrD",    InstrD,               got.instrd);
        chk("PCPlus4D",  PCPlus4D,             got.pcp4d);
        chk("validD",    32'(validD),          32'(got.vd));
        chk("CtrlE",     32'(CtrlE),           32'(got.ctrle));
        chk("RD1E",      RD1E,                 got.rd1e);
        chk("RD2E",      RD2E,                 got.rd2e);
        chk("SignImmE",  SignImmE,             got.imme);
        chk("rs_rt_rdE", {17'd0, rsE, rtE, rdE}, {17'd0, got.rse, got.rte, got.rde});
        chk("validE",    32'(validE),          32'(got.ve));
        chk("stall_cnt", 32'(stall_cnt),       32'(got.sc));
        chk("flush_cnt", 32'(flush_cnt),       32'(got.fc));
        chk("timeout",   32'(stall_timeout),   32'(got.to));
    endtask

    task automatic run(input logic sf, input logic sd, input logic fe, input logic ps, input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, sf, sd, fe, ps, $urandom, $urandom);
    endtask

    initial begin
        model_reset();
        reset = 1'b1; StallF = 0; StallD = 0; FlushE = 0; PCSrcD = 0;
        PCNextF = 0; InstrF = 0; PCPlus4F = 0; CtrlD = 0;
        RD1D = 0; RD2D = 0; SignImmD = 0; rsD_in = 0; rtD_in = 0; rdD_in = 0;
        @(negedge clk);

        // Reset state, then first fetch after release
        step(1, 0, 0, 0, 0, 32'h0, 32'h0);
        step(1, 1, 1, 1, 1, 32'h0, 32'h0);
        chk("reset_pc_const", PCF, 32'h0000_0400);
        step(0, 0, 0, 0, 0, 32'h404, 32'h2008_0001);
        chk("pc_after_release", PCF, 32'h0000_0404);
        chk("validE_still_0", 32'(validE), 32'd0);
        step(0, 0, 0, 0, 0, 32'h408, 32'h8C08_0004);
        chk("validE_two_cycles", 32'(validE), 32'd1);

        // Load-use stall with bubble into E
        step(0, 1, 1, 1, 0, 32'hDEAD_0000, 32'h1111_1111);
        chk("lu_instrD_held", InstrD, 32'h8C08_0004);
        chk("lu_pc_held", PCF, 32'h0000_0408);
        chk("lu_validE", 32'(validE), 32'd0);

        // Branch taken, then branch taken while D is stalled
        run(0, 0, 0, 0, 2);
        step(0, 0, 0, 0, 1, 32'h500, 32'h2222_2222);
        run(0, 0, 0, 0, 2);
        step(0, 0, 1, 0, 1, 32'h600, 32'h3333_3333);
        step(0, 1, 1, 1, 1, 32'h700, 32'h4444_4444);
        run(0, 0, 0, 0, 2);

        // Watchdog: 63-cycle run must not trip, 64-cycle run must
        run(1, 1, 0, 0, 63);
        chk("wd_63_quiet", 32'(stall_timeout), 32'd0);
        run(0, 0, 0, 0, 1);
        run(1, 1, 0, 0, 63);
        chk("wd_pre_64", 32'(stall_timeout), 32'd0);
        run(1, 1, 0, 0, 1);
        chk("wd_at_64", 32'(stall_timeout), 32'd1);
        run(0, 0, 0, 0, 5);
        chk("wd_sticky", 32'(stall_timeout), 32'd1);

        // Counter saturation at all-ones
        run(1, 0, 0, 0, 140);
        chk("stall_sat", 32'(stall_cnt), 32'h0000_00FF);
        run(0, 0, 1, 1, 260);
        chk("flush_sat", 32'(flush_cnt), 32'h0000_00FF);
        run(0, 0, 0, 0, 3);

        // Reset in the middle of a D stall
        step(1, 0, 1, 0, 0, 32'h900, 32'h5555_5555);
        chk("rst_timeout_clr", 32'(stall_timeout), 32'd0);
        run(0, 0, 0, 0, 3);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout bench did not complete");
        $fatal(1, "bench timeout");
    end

endmodule
